// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared state encoding and ALU opcodes for the ALU scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_SHLA = 3'b110;
  localparam logic [2:0] OP_SHLB = 3'b111;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin arbiter; pointer register lives in the parent
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // Contention resolved by ptr; a lone request always wins.
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - shares one combinational ALU between two requesters with a registered response
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int n  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [n-1:0]  req0_a,
  input  logic [n-1:0]  req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [n-1:0]  req1_a,
  input  logic [n-1:0]  req1_b,
  input  logic [2:0]    req1_op,
  output logic [n-1:0]  alu_a,
  output logic [n-1:0]  alu_b,
  output logic [2:0]    alu_op,
  input  logic [n-1:0]  alu_result,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic          alu_cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [n-1:0]  rsp_result,
  output logic          rsp_z,
  output logic          rsp_c,
  output logic          rsp_cout,
  output logic [CW-1:0] op_count
);

  state_t     state, state_next;
  logic       ptr;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       arb_en;

  // Gating on rst keeps readies low during reset even while state is still stale.
  assign arb_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .req    ({req1_valid, req0_valid}),
    .ptr    (ptr),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|gnt) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'b000;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_cout   <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            alu_a  <= gnt_id ? req1_a  : req0_a;
            alu_b  <= gnt_id ? req1_b  : req0_b;
            alu_op <= gnt_id ? req1_op : req0_op;
            rsp_id <= gnt_id;
            ptr    <= ~gnt_id;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_z      <= alu_z;
          rsp_c      <= alu_c;
          rsp_cout   <= alu_cout;
          rsp_valid  <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - randomized self-checking bench for alu_scheduler with a behavioural ALU
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_z, alu_c, alu_cout;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_z, rsp_c, rsp_cout;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.n(8), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_cout(rsp_cout),
    .op_count(op_count)
  );

  // Returns {cout, c, z, result}.
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] w;
    case (op)
      OP_ADD:  w = {1'b0, a} + {1'b0, b};
      OP_SUB:  w = {1'b0, a} - {1'b0, b};
      OP_AND:  w = {1'b0, a & b};
      OP_OR:   w = {1'b0, a | b};
      OP_XOR:  w = {1'b0, a ^ b};
      OP_GT:   w = {8'd0, a > b};
      OP_SHLA: w = {a, 1'b0};
      default: w = {b, 1'b0};
    endcase
    return {w[8], a > b, w[7:0] == 8'd0, w[7:0]};
  endfunction

  always_comb {alu_cout, alu_c, alu_z, alu_result} = alu_ref(alu_a, alu_b, alu_op);

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic send_one(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic [10:0] exp, input string name);
    int   waited;
    logic got;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    waited = 0;
    @(negedge clk);
    got = (id == 0) ? req0_ready : req1_ready;
    while (got !== 1'b1 && waited < 8) begin
      @(negedge clk); waited++;
      got = (id == 0) ? req0_ready : req1_ready;
    end
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL %s accept: ready=%b required 1", name, got); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_valid at T+1: got %b required 0", name, rsp_valid); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid at T+2: got %b required 1", name, rsp_valid); end
    checks++;
    if ({rsp_cout, rsp_c, rsp_z, rsp_result} !== exp) begin
      errors++; $display("FAIL %s data {cout,c,z,res}: got %h required %h", name, {rsp_cout, rsp_c, rsp_z, rsp_result}, exp);
    end
    checks++;
    if (rsp_id !== id[0]) begin errors++; $display("FAIL %s rsp_id: got %b required %b", name, rsp_id, id[0]); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count++;
    checks++;
    if (op_count !== 8'(exp_count) || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s after handshake: op_count=%0d rsp_valid=%b required %0d and 0", name, op_count, rsp_valid, 8'(exp_count));
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset readies: got %b required 00", {req0_ready, req1_ready}); end
    checks++;
    if ({alu_a, alu_b, alu_op} !== 19'd0) begin errors++; $display("FAIL reset alu regs: got %h required 0", {alu_a, alu_b, alu_op}); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_z, rsp_c, rsp_cout, op_count} !== 21'd0) begin
      errors++; $display("FAIL reset rsp regs: got %h required 0", {rsp_valid, rsp_id, rsp_result, rsp_z, rsp_c, rsp_cout, op_count});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_directed;
    send_one(0, 8'hF0, 8'h20, OP_ADD, 11'b110_0001_0000, "add_f0_20");
    send_one(0, 8'h05, 8'h05, OP_SUB, 11'b001_0000_0000, "sub_05_05");
  endtask

  task automatic test_random;
    logic [7:0] a, b;
    logic [2:0] op;
    int         id;
    for (int i = 0; i < 16; i++) begin
      id = $urandom_range(0, 1);
      a  = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      send_one(id, a, b, op, alu_ref(a, b, op), "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] q[$];
    logic [11:0] e;
    int          mptr, grants, last, gid, cyc;
    do_reset;
    mptr = 0; grants = 0; last = -1; cyc = 0;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    while (cyc < 80 && grants < 12) begin
      @(negedge clk);
      if (rsp_valid) begin
        e = q.size() > 0 ? q.pop_front() : 12'hFFF;
        checks++;
        if ({rsp_id, rsp_cout, rsp_c, rsp_z, rsp_result} !== e || op_count !== 8'(exp_count)) begin
          errors++; $display("FAIL b2b response: got id/data %h count %0d required %h count %0d",
                             {rsp_id, rsp_cout, rsp_c, rsp_z, rsp_result}, op_count, e, 8'(exp_count));
        end
        exp_count++;
      end
      if (req0_ready || req1_ready) begin
        gid = req1_ready ? 1 : 0;
        checks++;
        if ((req0_ready && req1_ready) || gid != mptr) begin
          errors++; $display("FAIL b2b grant: readies=%b required grant to %0d", {req1_ready, req0_ready}, mptr);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin errors++; $display("FAIL b2b interval: got %0d required 3", cyc - last); end
        end
        last = cyc;
        grants++;
        if (gid == 0) q.push_back({1'b0, alu_ref(req0_a, req0_b, req0_op)});
        else          q.push_back({1'b1, alu_ref(req1_a, req1_b, req1_op)});
        mptr = 1 - gid;
        @(posedge clk); #1;
        if (gid == 0) begin req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom); end
        else          begin req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom); end
      end
      cyc++;
    end
    checks++;
    if (grants != 12) begin errors++; $display("FAIL b2b grant count: got %0d required 12", grants); end
    do_reset;
  endtask

  task automatic test_backpressure;
    logic [10:0] snap;
    logic [10:0] exp;
    int          waited;
    do_reset;
    @(posedge clk); #1;
    req1_a = 8'h9C; req1_b = 8'h3A; req1_op = OP_XOR; req1_valid = 1'b1;
    exp = alu_ref(8'h9C, 8'h3A, OP_XOR);
    waited = 0;
    @(negedge clk);
    while (req1_ready !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
    @(posedge clk); #1;
    req0_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && waited < 6) begin @(negedge clk); waited++; end
    snap = {rsp_cout, rsp_c, rsp_z, rsp_result};
    checks++;
    if (snap !== exp || rsp_id !== 1'b1 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL bp first response: got %h id %b valid %b required %h id 1 valid 1", snap, rsp_id, rsp_valid, exp);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_cout, rsp_c, rsp_z, rsp_result} !== exp || rsp_id !== 1'b1 ||
          {req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL bp hold cycle %0d: valid %b data %h id %b readies %b required 1 %h 1 00",
                           i, rsp_valid, {rsp_cout, rsp_c, rsp_z, rsp_result}, rsp_id, {req1_ready, req0_ready}, exp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b01 || op_count !== 8'd1) begin
      errors++; $display("FAIL bp release: valid %b readies %b count %0d required 0 01 1", rsp_valid, {req1_ready, req0_ready}, op_count);
    end
    do_reset;
  endtask

  task automatic test_reset_mid;
    int waited;
    do_reset;
    @(posedge clk); #1;
    req0_a = 8'h11; req0_b = 8'h22; req0_op = OP_OR; req0_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (req0_ready !== 1'b1 && waited < 8) begin @(negedge clk); waited++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 8'd0) begin
        errors++; $display("FAIL midrst drop cycle %0d: valid %b count %0d required 0 0", i, rsp_valid, op_count);
      end
    end
    @(posedge clk); #1;
    req0_a = 8'h33; req0_b = 8'h44; req0_op = OP_AND; req0_valid = 1'b1;
    req1_a = 8'h55; req1_b = 8'h66; req1_op = OP_ADD; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL midrst priority: readies %b required 01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || {rsp_cout, rsp_c, rsp_z, rsp_result} !== alu_ref(8'h33, 8'h44, OP_AND)) begin
      errors++; $display("FAIL midrst response: valid %b id %b data %h required 1 0 %h",
                         rsp_valid, rsp_id, {rsp_cout, rsp_c, rsp_z, rsp_result}, alu_ref(8'h33, 8'h44, OP_AND));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (op_count !== 8'd1) begin errors++; $display("FAIL midrst count: got %0d required 1", op_count); end
    do_reset;
  endtask

  task automatic test_wrap;
    int hs, cyc;
    do_reset;
    hs = 0; cyc = 0;
    req0_a = 8'h01; req0_b = 8'h02; req0_op = OP_ADD; req0_valid = 1'b1; rsp_ready = 1'b1;
    while (hs < 256 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        hs++;
        @(posedge clk); #1;
        if (hs == 255) begin
          checks++;
          if (op_count !== 8'hFF) begin errors++; $display("FAIL wrap at 255: got %h required ff", op_count); end
        end
        if (hs == 256) begin
          checks++;
          if (op_count !== 8'h00) begin errors++; $display("FAIL wrap at 256: got %h required 00", op_count); end
        end
      end
    end
    checks++;
    if (hs != 256) begin errors++; $display("FAIL wrap handshakes: got %0d required 256", hs); end
    do_reset;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
